hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports id_rs1, id_rs2, input, 5 bits each: source register indices of the instruction in ID.
REQ-004 SHALL have ports id_uses_rs1, id_uses_rs2, input, 1 bit each: the ID instruction reads that source.
REQ-005 SHALL have ports id_rd (input, 5 bits), id_regwrite (input, 1 bit) and id_is_load (input, 1 bit): destination, register-write and load attributes of the ID instruction.
REQ-006 SHALL have port id_valid, input, 1 bit: the ID slot holds a real instruction.
REQ-007 SHALL have port mem_stall, input, 1 bit: global pipeline freeze from a cache miss.
REQ-008 SHALL have port flush, input, 1 bit: branch/jump redirect resolved in EX.
REQ-009 SHALL have ports forwardA, forwardB, output, 2 bits each: execute-stage operand selects; 00 = register file, 01 = writeback value, 10 = MEM-stage ALU result.
REQ-010 SHALL have port stall_if_id, output, 1 bit: hold the PC and the IF/ID register.
REQ-011 SHALL have port bubble_ex, output, 1 bit: load a NOP into ID/EX.
REQ-012 SHALL have port stall_count, output, 32 bits: count of hazard stall cycles.

Function
REQ-013 SHALL keep shadow entries EX, MEM and WB, each holding {valid, rd, regwrite, is_load}; EX additionally holds rs1, rs2, uses_rs1, uses_rs2.
REQ-014 SHALL, when mem_stall=1, hold all entries and stall_count; outputs are recomputed from the held state.
REQ-015 SHALL, when mem_stall=0, shift WB<=MEM and MEM<=EX each cycle.
REQ-016 SHALL load EX<=ID when mem_stall=0, id_valid=1, flush=0 and stall_if_id=0; otherwise EX SHALL become a bubble (valid=0).
REQ-017 SHALL treat an entry as a producer only when valid=1, regwrite=1 and rd!=0.
REQ-018 SHALL compute forwardA combinationally from registered state: 10 when the EX entry uses rs1 and a MEM producer with is_load=0 has rd=EX.rs1; else 01 when a WB producer has rd=EX.rs1; else 00. forwardB follows the same rule for rs2.
REQ-019 SHALL give MEM priority over WB when both match the same source.
REQ-020 SHALL assert stall_if_id and bubble_ex for the load-use case: the EX entry is a producer with is_load=1 and its rd matches an ID source in use. The stall SHALL last exactly 1 cycle, after which the operand is forwarded from WB (01).
REQ-021 SHALL let flush dominate: when flush=1, stall_if_id=0, bubble_ex=1, and no hazard check is made against ID.
REQ-022 SHALL increment stall_count, wrapping modulo 2^32, on each cycle with stall_if_id=1 and mem_stall=0.
REQ-023 SHALL keep forwardA/forwardB at 00 whenever the EX entry is invalid.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, clear valid in all entries and set stall_count=0. After that edge, forwardA=forwardB=00 and stall_if_id=bubble_ex=0.
REQ-025 SHALL give rst priority over mem_stall and flush; a reset mid-stall SHALL abandon all hazard state.

Configuration
REQ-026 SHALL compile forwarding in only when HAZARD_FORWARDING_EN is defined, with the behaviour given in REQ-018 to REQ-020.
REQ-027 SHALL, when HAZARD_FORWARDING_EN is undefined, drive forwardA=forwardB=00 permanently. It SHALL also assert stall_if_id and bubble_ex while any EX, MEM or WB producer's rd matches an ID source in use, whether or not that producer is a load.

Verification
REQ-028 SHALL cover: add x5,x1,x2 then sub x6,x5,x3 back-to-back -> forwardA=10 in the sub's EX cycle, no stall.
REQ-029 SHALL cover: lw x5,0(x1) then add x6,x5,x5 -> stall_if_id=1 for 1 cycle, then forwardA=forwardB=01, stall_count=1.
REQ-030 SHALL cover: addi x0,x0,1 then add x7,x0,x0 -> forwardA=forwardB=00.
REQ-031 SHALL cover: x5 written in both MEM and WB, consumer reads x5 -> forwardA=10.
REQ-032 SHALL cover: load-use stall with flush=1 in the same cycle -> stall_if_id=0, bubble_ex=1; mem_stall=1 for 3 cycles mid-sequence -> state and stall_count frozen.
REQ-033 SHALL cover: with HAZARD_FORWARDING_EN undefined, add x5 then sub using x5 -> 3 stall cycles, forward selects always 00.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: tracks the EX, MEM and WB occupants of a 5-stage pipeline
// and produces operand-forwarding selects, load-use stall and bubble controls,
// and a running count of hazard stall cycles.
// Build option: define HAZARD_FORWARDING_EN to compile in forwarding. Without
// it the forward selects stay at 00 and any in-flight producer of an ID source
// stalls the front end until it has left WB.
module hazard_forward_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  id_rd,
   input  logic        id_regwrite,
   input  logic        id_is_load,
   input  logic        id_valid,
   input  logic        mem_stall,
   input  logic        flush,
   output logic [1:0]  forwardA,
   output logic [1:0]  forwardB,
   output logic        stall_if_id,
   output logic        bubble_ex,
   output logic [31:0] stall_count
);

   // Shadow pipeline entries: valid bits are control, the rest is payload.
   logic       ex_valid, mem_valid, wb_valid;
   logic [4:0] ex_rd, mem_rd, wb_rd;
   logic       ex_regwrite, mem_regwrite, wb_regwrite;
   logic       ex_is_load, mem_is_load, wb_is_load;
   logic [4:0] ex_rs1, ex_rs2;
   logic       ex_uses_rs1, ex_uses_rs2;

   logic ex_prod, mem_prod, wb_prod;
   logic id_hit_ex, id_hit_mem, id_hit_wb;
   logic hazard;
   logic load_ex;

   // An entry only produces a value when it is real, writes, and is not x0.
   function automatic logic is_producer(input logic valid, input logic regwrite,
                                        input logic [4:0] rd);
      return valid & regwrite & (rd != 5'd0);
   endfunction

   // True when the ID instruction reads register rd through either used source.
   function automatic logic id_reads(input logic valid,
                                     input logic [4:0] rs1, input logic uses1,
                                     input logic [4:0] rs2, input logic uses2,
                                     input logic [4:0] rd);
      return valid & ((uses1 & (rs1 == rd)) | (uses2 & (rs2 == rd)));
   endfunction

   // Operand select for one EX source: MEM ALU result beats WB value.
   function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                          input logic mem_ok, input logic [4:0] mrd,
                                          input logic wb_ok, input logic [4:0] wrd);
      if (!used)                      return 2'b00;
      else if (mem_ok && mrd == src)  return 2'b10;
      else if (wb_ok && wrd == src)   return 2'b01;
      else                            return 2'b00;
   endfunction

   // Producer qualification and ID source matching against each stage.
   always_comb begin
      ex_prod    = is_producer(ex_valid, ex_regwrite, ex_rd);
      mem_prod   = is_producer(mem_valid, mem_regwrite, mem_rd);
      wb_prod    = is_producer(wb_valid, wb_regwrite, wb_rd);
      id_hit_ex  = id_reads(id_valid, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2, ex_rd);
      id_hit_mem = id_reads(id_valid, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2, mem_rd);
      id_hit_wb  = id_reads(id_valid, id_rs1, id_uses_rs1, id_rs2, id_uses_rs2, wb_rd);
   end

`ifdef HAZARD_FORWARDING_EN
   // Only a load in EX cannot be bypassed in time; everything else forwards.
   logic unused_attrs;
   assign unused_attrs = ^{wb_is_load, mem_prod & id_hit_mem, wb_prod & id_hit_wb};

   // Forward selects derived purely from registered state.
   always_comb begin
      hazard   = ex_prod & ex_is_load & id_hit_ex;
      forwardA = 2'b00;
      forwardB = 2'b00;
      if (ex_valid) begin
         forwardA = fwd_sel(ex_uses_rs1, ex_rs1, mem_prod & ~mem_is_load, mem_rd,
                            wb_prod, wb_rd);
         forwardB = fwd_sel(ex_uses_rs2, ex_rs2, mem_prod & ~mem_is_load, mem_rd,
                            wb_prod, wb_rd);
      end
   end
`else
   // Without bypass paths every in-flight producer of an ID source must drain.
   logic unused_attrs;
   assign unused_attrs = ^{ex_is_load, mem_is_load, wb_is_load, ex_rs1, ex_rs2,
                           ex_uses_rs1, ex_uses_rs2,
                           fwd_sel(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0)};

   // Stall on any producer match; operands always come from the register file.
   always_comb begin
      hazard   = (ex_prod & id_hit_ex) | (mem_prod & id_hit_mem) | (wb_prod & id_hit_wb);
      forwardA = 2'b00;
      forwardB = 2'b00;
   end
`endif

   // Flush dominates: the redirected ID slot is discarded, so no stall is raised.
   always_comb begin
      stall_if_id = ~flush & hazard;
      bubble_ex   = flush | stall_if_id;
      load_ex     = id_valid & ~flush & ~stall_if_id;
   end

   // Control state: valid bits and the stall counter; frozen while memory stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         mem_valid   <= 1'b0;
         wb_valid    <= 1'b0;
         stall_count <= 32'd0;
      end else if (!mem_stall) begin
         wb_valid  <= mem_valid;
         mem_valid <= ex_valid;
         ex_valid  <= load_ex;
         if (stall_if_id)
            stall_count <= stall_count + 32'd1;
      end
   end

   // Payload shift; contents are only meaningful when the matching valid is set.
   always_ff @(posedge clk) begin
      if (!mem_stall) begin
         wb_rd        <= mem_rd;
         wb_regwrite  <= mem_regwrite;
         wb_is_load   <= mem_is_load;
         mem_rd       <= ex_rd;
         mem_regwrite <= ex_regwrite;
         mem_is_load  <= ex_is_load;
         if (load_ex) begin
            ex_rd       <= id_rd;
            ex_regwrite <= id_regwrite;
            ex_is_load  <= id_is_load;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_uses_rs1 <= id_uses_rs1;
            ex_uses_rs2 <= id_uses_rs2;
         end
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Testbench for hazard_forward_unit: directed pipeline scenarios plus a
// randomized run against an instruction-level reference model. Expectations
// follow the build option HAZARD_FORWARDING_EN.
module tb_hazard_forward_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_uses_rs1, id_uses_rs2, id_regwrite, id_is_load, id_valid;
   logic        mem_stall, flush;
   logic [1:0]  forwardA, forwardB;
   logic        stall_if_id, bubble_ex;
   logic [31:0] stall_count;

   int checks = 0;
   int errors = 0;

`ifdef HAZARD_FORWARDING_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   hazard_forward_unit dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
      .id_valid(id_valid), .mem_stall(mem_stall), .flush(flush),
      .forwardA(forwardA), .forwardB(forwardB),
      .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
      .stall_count(stall_count)
   );

   // Reference model: the instructions currently sitting in EX, MEM and WB.
   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       rw;
      bit       ld;
      bit [4:0] rs1;
      bit [4:0] rs2;
      bit       u1;
      bit       u2;
   } ent_t;

   ent_t        m_ex, m_mem, m_wb;
   bit   [31:0] m_cnt;

   function automatic bit producer(ent_t e);
      return e.v && e.rw && (e.rd != 5'd0);
   endfunction

   function automatic bit id_reads(bit [4:0] r);
      return id_valid && ((id_uses_rs1 && id_rs1 == r) || (id_uses_rs2 && id_rs2 == r));
   endfunction

   function automatic bit exp_stall();
      if (flush) return 1'b0;
      if (FWD_EN) return producer(m_ex) && m_ex.ld && id_reads(m_ex.rd);
      return (producer(m_ex) && id_reads(m_ex.rd)) ||
             (producer(m_mem) && id_reads(m_mem.rd)) ||
             (producer(m_wb) && id_reads(m_wb.rd));
   endfunction

   function automatic bit [1:0] exp_fwd(bit used, bit [4:0] src);
      if (!FWD_EN || !m_ex.v || !used) return 2'b00;
      if (producer(m_mem) && !m_mem.ld && m_mem.rd == src) return 2'b10;
      if (producer(m_wb) && m_wb.rd == src) return 2'b01;
      return 2'b00;
   endfunction

   // Advance one clock: the model takes the same edge as the DUT.
   task automatic tick();
      bit st;
      @(posedge clk);
      st = exp_stall();
      if (rst) begin
         m_ex.v = 1'b0; m_mem.v = 1'b0; m_wb.v = 1'b0; m_cnt = 32'd0;
      end else if (!mem_stall) begin
         if (st) m_cnt = m_cnt + 32'd1;
         m_wb  = m_mem;
         m_mem = m_ex;
         if (id_valid && !flush && !st)
            m_ex = '{1'b1, id_rd, id_regwrite, id_is_load, id_rs1, id_rs2,
                     id_uses_rs1, id_uses_rs2};
         else
            m_ex.v = 1'b0;
      end
      #1;
   endtask

   task automatic set_id(input bit v, input bit [4:0] rd, input bit rw, input bit ld,
                         input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2);
      id_valid = v; id_rd = rd; id_regwrite = rw; id_is_load = ld;
      id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
   endtask

   task automatic do_reset();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      mem_stall = 0; flush = 0; rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      set_id(1, 5'd9, 1, 0, 5'd5, 1, 5'd6, 1);
      #1;
      checks++;
      if (forwardA !== 2'b00 || forwardB !== 2'b00) begin
         errors++; $display("FAIL reset_fwd got %b/%b want 00/00", forwardA, forwardB);
      end
      checks++;
      if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0) begin
         errors++; $display("FAIL reset_ctl stall=%b bubble=%b want 0/0", stall_if_id, bubble_ex);
      end
      checks++;
      if (stall_count !== 32'd0) begin
         errors++; $display("FAIL reset_count got %0d want 0", stall_count);
      end
   endtask

   // add x5,x1,x2 ; sub x6,x5,x3
   task automatic test_alu_forward();
      int n_exp;
      bit [31:0] c0;
      do_reset();
      n_exp = FWD_EN ? 0 : 3;
      c0 = stall_count;
      set_id(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1);
      tick();
      set_id(1, 5'd6, 1, 0, 5'd5, 1, 5'd3, 1);
      for (int i = 0; i < n_exp; i++) begin
         #1;
         checks++;
         if (stall_if_id !== 1'b1 || bubble_ex !== 1'b1 || forwardA !== 2'b00) begin
            errors++; $display("FAIL alu_stall_%0d stall=%b bubble=%b fA=%b want 1/1/00",
                               i, stall_if_id, bubble_ex, forwardA);
         end
         tick();
      end
      #1;
      checks++;
      if (stall_if_id !== 1'b0) begin
         errors++; $display("FAIL alu_nostall got %b want 0", stall_if_id);
      end
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (forwardA !== (FWD_EN ? 2'b10 : 2'b00) || forwardB !== 2'b00) begin
         errors++; $display("FAIL alu_fwd got %b/%b want %b/00", forwardA, forwardB,
                            FWD_EN ? 2'b10 : 2'b00);
      end
      checks++;
      if (stall_count - c0 !== n_exp) begin
         errors++; $display("FAIL alu_count got %0d want %0d", stall_count - c0, n_exp);
      end
   endtask

   // lw x5,0(x1) ; add x6,x5,x5
   task automatic test_load_use();
      int n_exp;
      do_reset();
      n_exp = FWD_EN ? 1 : 3;
      set_id(1, 5'd5, 1, 1, 5'd1, 1, 5'd0, 0);
      tick();
      set_id(1, 5'd6, 1, 0, 5'd5, 1, 5'd5, 1);
      for (int i = 0; i < n_exp; i++) begin
         #1;
         checks++;
         if (stall_if_id !== 1'b1 || bubble_ex !== 1'b1) begin
            errors++; $display("FAIL lu_stall_%0d stall=%b bubble=%b want 1/1",
                               i, stall_if_id, bubble_ex);
         end
         tick();
      end
      #1;
      checks++;
      if (stall_if_id !== 1'b0) begin
         errors++; $display("FAIL lu_release got %b want 0", stall_if_id);
      end
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (forwardA !== (FWD_EN ? 2'b01 : 2'b00) || forwardB !== (FWD_EN ? 2'b01 : 2'b00)) begin
         errors++; $display("FAIL lu_fwd got %b/%b want %b", forwardA, forwardB,
                            FWD_EN ? 2'b01 : 2'b00);
      end
      checks++;
      if (stall_count !== n_exp) begin
         errors++; $display("FAIL lu_count got %0d want %0d", stall_count, n_exp);
      end
   endtask

   // addi x0,x0,1 ; add x7,x0,x0
   task automatic test_x0();
      do_reset();
      set_id(1, 5'd0, 1, 0, 5'd0, 1, 5'd0, 0);
      tick();
      set_id(1, 5'd7, 1, 0, 5'd0, 1, 5'd0, 1);
      #1;
      checks++;
      if (stall_if_id !== 1'b0) begin
         errors++; $display("FAIL x0_stall got %b want 0", stall_if_id);
      end
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (forwardA !== 2'b00 || forwardB !== 2'b00) begin
         errors++; $display("FAIL x0_fwd got %b/%b want 00/00", forwardA, forwardB);
      end
   endtask

   // add x5 ; add x5 ; sub x6,x5,x3 -> younger (MEM) copy wins
   task automatic test_mem_priority();
      int n_exp;
      do_reset();
      n_exp = FWD_EN ? 0 : 3;
      set_id(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1);
      tick();
      set_id(1, 5'd5, 1, 0, 5'd3, 1, 5'd4, 1);
      tick();
      set_id(1, 5'd6, 1, 0, 5'd5, 1, 5'd3, 1);
      for (int i = 0; i < n_exp; i++) begin
         #1;
         checks++;
         if (stall_if_id !== 1'b1) begin
            errors++; $display("FAIL prio_stall_%0d got %b want 1", i, stall_if_id);
         end
         tick();
      end
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (forwardA !== (FWD_EN ? 2'b10 : 2'b00)) begin
         errors++; $display("FAIL prio_fwd got %b want %b", forwardA, FWD_EN ? 2'b10 : 2'b00);
      end
   endtask

   // load-use pair with flush in the same cycle
   task automatic test_flush();
      do_reset();
      set_id(1, 5'd5, 1, 1, 5'd1, 1, 5'd0, 0);
      tick();
      set_id(1, 5'd6, 1, 0, 5'd5, 1, 5'd5, 1);
      flush = 1;
      #1;
      checks++;
      if (stall_if_id !== 1'b0 || bubble_ex !== 1'b1) begin
         errors++; $display("FAIL flush_ctl stall=%b bubble=%b want 0/1", stall_if_id, bubble_ex);
      end
      tick();
      flush = 0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (forwardA !== 2'b00 || stall_if_id !== 1'b0 || stall_count !== 32'd0) begin
         errors++; $display("FAIL flush_after fA=%b stall=%b cnt=%0d want 00/0/0",
                            forwardA, stall_if_id, stall_count);
      end
   endtask

   // memory freeze for 3 cycles in the middle of a load-use stall
   task automatic test_mem_stall();
      int n_exp;
      do_reset();
      n_exp = FWD_EN ? 1 : 3;
      set_id(1, 5'd5, 1, 1, 5'd1, 1, 5'd0, 0);
      tick();
      set_id(1, 5'd6, 1, 0, 5'd5, 1, 5'd5, 1);
      mem_stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (stall_if_id !== 1'b1 || stall_count !== 32'd0) begin
            errors++; $display("FAIL freeze_%0d stall=%b cnt=%0d want 1/0", i, stall_if_id,
                               stall_count);
         end
      end
      mem_stall = 0;
      for (int i = 0; i < n_exp; i++) begin
         #1;
         checks++;
         if (stall_if_id !== 1'b1) begin
            errors++; $display("FAIL thaw_stall_%0d got %b want 1", i, stall_if_id);
         end
         tick();
      end
      #1;
      checks++;
      if (stall_if_id !== 1'b0 || stall_count !== n_exp) begin
         errors++; $display("FAIL thaw_done stall=%b cnt=%0d want 0/%0d", stall_if_id,
                            stall_count, n_exp);
      end
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (forwardA !== (FWD_EN ? 2'b01 : 2'b00)) begin
         errors++; $display("FAIL thaw_fwd got %b want %b", forwardA, FWD_EN ? 2'b01 : 2'b00);
      end
   endtask

   // reset during a frozen load-use stall abandons everything
   task automatic test_reset_mid_stall();
      do_reset();
      set_id(1, 5'd5, 1, 1, 5'd1, 1, 5'd0, 0);
      tick();
      set_id(1, 5'd6, 1, 0, 5'd5, 1, 5'd5, 1);
      tick();
      mem_stall = 1; flush = 1; rst = 1;
      tick();
      mem_stall = 0; flush = 0; rst = 0;
      #1;
      checks++;
      if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0 || stall_count !== 32'd0 ||
          forwardA !== 2'b00) begin
         errors++; $display("FAIL rst_mid stall=%b bubble=%b cnt=%0d fA=%b want 0/0/0/00",
                            stall_if_id, bubble_ex, stall_count, forwardA);
      end
   endtask

   // randomized traffic on a small register window to provoke many matches
   task automatic test_random();
      bit [1:0]  ea, eb;
      bit        es, ebub;
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 99) < 2);
         mem_stall = ($urandom_range(0, 99) < 15);
         flush     = ($urandom_range(0, 99) < 10);
         set_id($urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         #1;
         ea   = exp_fwd(m_ex.u1, m_ex.rs1);
         eb   = exp_fwd(m_ex.u2, m_ex.rs2);
         es   = exp_stall();
         ebub = flush || es;
         checks++;
         if ({forwardA, forwardB, stall_if_id, bubble_ex} !== {ea, eb, es, ebub} ||
             stall_count !== m_cnt) begin
            errors++;
            $display("FAIL random_%0d got fA=%b fB=%b st=%b bub=%b cnt=%0d want %b %b %b %b %0d",
                     i, forwardA, forwardB, stall_if_id, bubble_ex, stall_count,
                     ea, eb, es, ebub, m_cnt);
         end
         tick();
      end
      rst = 0; mem_stall = 0; flush = 0;
   endtask

   initial begin
      m_ex = '{default: 0}; m_mem = '{default: 0}; m_wb = '{default: 0}; m_cnt = 0;
      rst = 1; mem_stall = 0; flush = 0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_alu_forward();
      test_load_use();
      test_x0();
      test_mem_priority();
      test_flush();
      test_mem_stall();
      test_reset_mid_stall();
      do_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
